// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 host write path and register array.
package opl3_pkg;

  localparam int unsigned NUM_REG_BYTES  = 512;
  localparam int unsigned REG_ADDR_WIDTH = 9;
  localparam int unsigned BANK2_OFFSET   = 256;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_NEW_ADDR     = 9'h105;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_CONNSEL_ADDR = 9'h104;

  // One queued host register write.
  typedef struct packed {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } reg_wr_t;

  localparam int unsigned REG_WR_WIDTH = $bits(reg_wr_t);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    GAP    = 2'd2
  } wr_ctrl_state_t;

  // Bank-1 writes are only honoured in OPL3 mode, except the mode/connection registers.
  function automatic logic write_allowed(input reg_wr_t entry, input logic new_mode);
    logic [REG_ADDR_WIDTH-1:0] full_addr;
    full_addr = {entry.bank, entry.addr};
    return !entry.bank || new_mode ||
           (full_addr == REG_NEW_ADDR) || (full_addr == REG_CONNSEL_ADDR);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/opl3_host_write_ctrl.sv
// Host port write sequencer: queues data-port writes and commits them into the OPL3 register array.
module opl3_host_write_ctrl
  import opl3_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [1:0]                a,
  input  logic [7:0]                din,
  output logic                      wr_ready,
  output logic                      busy,
  output logic                      overflow,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]                reg_data,
  output logic [7:0]                slv8_reg [NUM_REG_BYTES]
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  wr_ctrl_state_t    state_q, state_n;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_n;
  reg_wr_t           hold_q, hold_n;
  logic              ok_q, ok_n;
  logic              pop_c;

  logic [7:0]        addr_latch;
  logic              bank_latch;
  logic              data_wr_c;
  logic              push_c;
  logic              new_mode_c;
  reg_wr_t           fifo_din;
  reg_wr_t           fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next_c;

  assign data_wr_c    = wr_en && a[0];
  assign push_c       = data_wr_c && !fifo_full;
  assign new_mode_c   = slv8_reg[REG_NEW_ADDR][0];
  assign fifo_din     = '{bank: bank_latch, addr: addr_latch, data: din};
  assign count_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

  sync_fifo #(
    .WIDTH (REG_WR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Address-port latch; address writes are never queued or blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_latch <= '0;
      bank_latch <= 1'b0;
    end else if (wr_en && !a[0]) begin
      addr_latch <= din;
      bank_latch <= a[1];
    end
  end

  // FSM state, gap counter and holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      hold_q    <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      gap_cnt_q <= gap_cnt_n;
      hold_q    <= hold_n;
      ok_q      <= ok_n;
    end
  end

  // Next-state: pop in IDLE (bank filter decided here), commit for one cycle, then hold off.
  always_comb begin
    state_n   = state_q;
    gap_cnt_n = gap_cnt_q;
    hold_n    = hold_q;
    ok_n      = ok_q;
    pop_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          hold_n  = fifo_dout;
          ok_n    = write_allowed(fifo_dout, new_mode_c);
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        gap_cnt_n = GAP_W'(GAP_CYCLES);
        state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_cnt_n = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered host-facing status and commit strobe (strobe spans the COMMIT cycle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_we   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      overflow <= 1'b0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      reg_we   <= pop_c && ok_n;
      if (pop_c && ok_n) begin
        reg_addr <= {hold_n.bank, hold_n.addr};
        reg_data <= hold_n.data;
      end
      if (data_wr_c && fifo_full) begin
        overflow <= 1'b1;
      end
      wr_ready <= (count_next_c != CNT_W'(FIFO_DEPTH));
      busy     <= (count_next_c != '0) || (state_n != IDLE);
    end
  end

  // Register array; one byte written at the end of each non-filtered COMMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REG_BYTES); i++) begin
        slv8_reg[i] <= '0;
      end
    end else if ((state_q == COMMIT) && ok_q) begin
      slv8_reg[{hold_q.bank, hold_q.addr}] <= hold_q.data;
    end
  end

endmodule

// File: tb/tb_opl3_host_write_ctrl.sv
// Scoreboard bench for opl3_host_write_ctrl: expected commits queued at push, checked at reg_we.
module tb_opl3_host_write_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [1:0] a;
  logic [7:0] din;
  logic       wr_ready;
  logic       busy;
  logic       overflow;
  logic       reg_we;
  logic [8:0] reg_addr;
  logic [7:0] reg_data;
  logic [7:0] slv8_reg [512];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [16:0] exp_q [$];
  logic [7:0]  sh [512];
  logic [7:0]  m_addr;
  logic        m_bank;

  bit spacing_en = 0;
  bit have_last  = 0;
  int last_we    = 0;

  opl3_host_write_ctrl #(
    .FIFO_DEPTH (16),
    .GAP_CYCLES (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .a        (a),
    .din      (din),
    .wr_ready (wr_ready),
    .busy     (busy),
    .overflow (overflow),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .slv8_reg (slv8_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: every reg_we must match the oldest expected entry.
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(reg_addr), 32'hFFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("commit_addr", 32'(reg_addr), 32'(e[16:8]));
        check("commit_data", 32'(reg_data), 32'(e[7:0]));
      end
      if (spacing_en && have_last) check("commit_spacing", 32'(cyc - last_we), 32'd10);
      have_last = 1;
      last_we   = cyc;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 512; i++) sh[i] = 8'h00;
    m_addr = 8'h00;
    m_bank = 1'b0;
  endtask

  // One host transfer, called at a negedge; returns at the following negedge.
  task automatic host_wr(input logic [1:0] aa, input logic [7:0] d, input bit acc);
    logic [8:0] fa;
    wr_en = 1'b1;
    a     = aa;
    din   = d;
    @(posedge clk);
    if (!aa[0]) begin
      m_addr = d;
      m_bank = aa[1];
    end else if (acc) begin
      fa = {m_bank, m_addr};
      if (!m_bank || sh[9'h105][0] || fa == 9'h104 || fa == 9'h105) begin
        exp_q.push_back({fa, d});
        sh[fa] = d;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    wr_en   = 1'b0;
    a       = 2'b00;
    din     = 8'h00;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_reg_we",   32'(reg_we),   32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", 32'(reg_data), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Single bank-0 write: latency and busy duration.
    host_wr(2'b00, 8'h20, 1);
    host_wr(2'b01, 8'h21, 1);
    check("t1_busy_set", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_we_pulse", 32'(reg_we), 32'd1);
    check("t1_arr_before", 32'(slv8_reg[9'h020]), 32'h00);
    @(negedge clk);
    check("t1_arr_after", 32'(slv8_reg[9'h020]), 32'h21);
    check("t1_we_dropped", 32'(reg_we), 32'd0);
    repeat (7) @(negedge clk);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_busy_clear", 32'(busy), 32'd0);

    // Queued commits are spaced GAP_CYCLES+2 apart, in order.
    have_last  = 0;
    spacing_en = 1;
    for (int i = 0; i < 3; i++) begin
      host_wr(2'b00, 8'hA0 + 8'(i), 1);
      host_wr(2'b01, 8'h60 + 8'(i), 1);
    end
    wait_idle(100);
    spacing_en = 0;
    check("burst_a0", 32'(slv8_reg[9'h0A0]), 32'h60);
    check("burst_a1", 32'(slv8_reg[9'h0A1]), 32'h61);
    check("burst_a2", 32'(slv8_reg[9'h0A2]), 32'h62);

    // Bank-1 filtering until OPL3 mode is enabled.
    host_wr(2'b10, 8'h20, 1);
    host_wr(2'b11, 8'h55, 1);
    wait_idle(100);
    check("bank1_blocked", 32'(slv8_reg[9'h120]), 32'h00);
    host_wr(2'b10, 8'h05, 1);
    host_wr(2'b11, 8'h01, 1);
    host_wr(2'b10, 8'h20, 1);
    host_wr(2'b11, 8'h55, 1);
    wait_idle(100);
    check("new_mode_set", 32'(slv8_reg[9'h105]), 32'h01);
    check("bank1_allowed", 32'(slv8_reg[9'h120]), 32'h55);

    // Each entry keeps the address latched at its own push.
    host_wr(2'b00, 8'h30, 1);
    host_wr(2'b01, 8'h31, 1);
    host_wr(2'b00, 8'h40, 1);
    host_wr(2'b01, 8'h41, 1);
    host_wr(2'b00, 8'h50, 1);
    wait_idle(100);
    check("latch_30", 32'(slv8_reg[9'h030]), 32'h31);
    check("latch_40", 32'(slv8_reg[9'h040]), 32'h41);
    check("latch_50", 32'(slv8_reg[9'h050]), 32'h00);

    // Overflow: 20 back-to-back data writes. Pops at the 2nd and 12th edge of the
    // burst free two slots, so the first 18 writes are accepted and the last 2 dropped.
    host_wr(2'b00, 8'h70, 1);
    for (int i = 0; i < 20; i++) begin
      host_wr(2'b01, 8'h80 + 8'(i), i < 18);
      if (i == 16) check("ovf_ready_before_full", 32'(wr_ready), 32'd1);
      if (i == 17) begin
        check("ovf_ready_full", 32'(wr_ready), 32'd0);
        check("ovf_not_yet", 32'(overflow), 32'd0);
      end
      if (i == 18) check("ovf_set", 32'(overflow), 32'd1);
    end
    wait_idle(1000);
    check("ovf_last_value", 32'(slv8_reg[9'h070]), 32'h91);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_ready_back", 32'(wr_ready), 32'd1);
    check("ovf_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset during GAP with five entries still queued.
    host_wr(2'b00, 8'h90, 1);
    for (int i = 0; i < 6; i++) host_wr(2'b01, 8'hC0 + 8'(i), 1);
    check("mid_busy", 32'(busy), 32'd1);
    model_reset();
    reset_n = 1'b0;
    #1;
    check("mid_rst_reg_we",   32'(reg_we),   32'd0);
    check("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
    check("mid_rst_reg_data", 32'(reg_data), 32'd0);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    nz = 0;
    for (int i = 0; i < 512; i++) if (slv8_reg[i] != 8'h00) nz++;
    check("mid_rst_array_zero", 32'(nz), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    check("post_rst_arr", 32'(slv8_reg[9'h090]), 32'h00);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
